// File: rtl/data_mem_responder.sv
// ============================================================================
// Module   : data_mem_responder
// Brief    : Single-outstanding valid/ready word memory with fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT     = 2'd1;
    localparam logic [1:0] c_RESP     = 2'd2;
    localparam logic [3:0] c_CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic            w_accept;
    logic            w_enter_resp;
    logic            w_we;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_be;
    logic            w_bad;
    logic [c_AW-1:0] w_idx;

    assign w_accept     = req_valid && (r_state == c_IDLE);
    assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                          ((r_state == c_WAIT) && (r_cnt == 4'd0));

    // With LATENCY=1 the access happens on the acceptance edge, so use the live request.
    assign w_we    = (r_state == c_IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == c_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == c_IDLE) ? req_wdata : r_wdata;
    assign w_be    = (r_state == c_IDLE) ? req_be    : r_be;

    assign w_bad = (w_addr[1:0] != 2'b00) ||
                   ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_idx = w_addr[c_AW+1:2];

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = (r_state == c_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        if (LATENCY == 1) begin
                            r_state <= c_RESP;
                        end else begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_CNT_LOAD;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_state <= c_IDLE;
                        r_rdata <= 32'd0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            if (w_enter_resp) begin
                r_rdata <= (w_we || w_bad) ? 32'd0 : r_mem[w_idx];
                r_err   <= w_bad;
            end
        end
    end

    // Storage is never reset; a reset aborts any pending write.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_we && !w_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench for data_mem_responder at LATENCY 1, 2 and 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            data_mem_responder #(
                .DEPTH_WORDS(1024),
                .LATENCY    ((g == 0) ? 1 : (g == 1) ? 2 : 4)
            ) u_dut (
                .clk      (clk),
                .rst      (rst[g]),
                .req_valid(req_valid[g]),
                .req_ready(req_ready[g]),
                .req_we   (req_we[g]),
                .req_addr (req_addr[g]),
                .req_wdata(req_wdata[g]),
                .req_be   (req_be[g]),
                .rsp_valid(rsp_valid[g]),
                .rsp_ready(rsp_ready[g]),
                .rsp_rdata(rsp_rdata[g]),
                .rsp_err  (rsp_err[g])
            );
        end
    endgenerate

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 4;
    endfunction

    function automatic void add(logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] be, logic [31:0] er, logic ee);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(int k, logic we, logic [31:0] addr, logic [31:0] wdata,
                          logic [3:0] be, logic [31:0] er, logic ee);
        int   c;
        exp_t e;
        c = 0;
        while (!req_ready[k] && c < 50) begin
            tick();
            c++;
        end
        chk("req_ready_idle", 32'(req_ready[k]), 32'd1);
        chk("rsp_valid_idle", 32'(rsp_valid[k]), 32'd0);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        tick();
        req_valid[k] = 1'b0;
        e.rdata = er;
        e.err   = ee;
        sb.push_back(e);
        c = 1;
        while (!rsp_valid[k] && c < 50) begin
            tick();
            c++;
        end
        chk("latency", 32'(c), 32'(lat_of(k)));
        rsp_ready[k] = 1'b1;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata[k], e.rdata);
        chk("rsp_err", 32'(rsp_err[k]), 32'(e.err));
        tick();
        rsp_ready[k] = 1'b0;
        chk("rsp_valid_after_hs", 32'(rsp_valid[k]), 32'd0);
        chk("rdata_zero_after_hs", rsp_rdata[k], 32'd0);
    endtask

    initial begin
        int   c;
        int   n_acc;
        exp_t e;

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0; rsp_ready[k] = 1'b0;
        end

        add(1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
        add(1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        add(1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0);
        add(1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0);
        add(1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0);
        add(1'b0, 32'h13,       32'h0,        4'h0, 32'h0,        1'b1);
        add(1'b1, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
        add(1'b1, 32'h1000,     32'h12345678, 4'hF, 32'h0,        1'b1);
        add(1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0);
        add(1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
        add(1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0);
        add(1'b1, 32'hFFC,      32'h01020304, 4'hF, 32'h0,        1'b0);
        add(1'b0, 32'hFFC,      32'h0,        4'h0, 32'h01020304, 1'b0);
        add(1'b0, 32'h1000,     32'h0,        4'h0, 32'h0,        1'b1);
        add(1'b1, 32'h22,       32'h0,        4'hF, 32'h0,        1'b1);
        add(1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0);
        add(1'b1, 32'h10,       32'h77000000, 4'h8, 32'h0,        1'b0);
        add(1'b0, 32'h10,       32'h0,        4'h0, 32'h77ADBEEF, 1'b0);
        add(1'b0, 32'h80000010, 32'h0,        4'h0, 32'h0,        1'b1);
        add(1'b1, 32'h80000000, 32'h0,        4'hF, 32'h0,        1'b1);
        add(1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0);

        tick();
        tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_req_ready", 32'(req_ready[k]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[k], 32'd0);
            chk("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
        end

        for (int k = 0; k < 3; k++) begin
            foreach (vecs[i]) begin
                do_txn(k, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                       vecs[i].exp_rdata, vecs[i].exp_err);
            end
        end

        // Backpressure on LATENCY=2 with a competing request held on the bus.
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h10;
        tick();
        req_we[1] = 1'b1; req_wdata[1] = 32'h0; req_be[1] = 4'hF;
        e.rdata = 32'h77ADBEEF; e.err = 1'b0;
        sb.push_back(e);
        c = 0;
        while (!rsp_valid[1] && c < 50) begin
            tick();
            c++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata[1], 32'h77ADBEEF);
            chk("bp_req_ready", 32'(req_ready[1]), 32'd0);
            tick();
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        e = sb.pop_front();
        chk("bp_final_rdata", rsp_rdata[1], e.rdata);
        chk("bp_final_err", 32'(rsp_err[1]), 32'(e.err));
        tick();
        rsp_ready[1] = 1'b0;
        chk("bp_after_hs_valid", 32'(rsp_valid[1]), 32'd0);
        do_txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h77ADBEEF, 1'b0);

        // Reset one cycle into WAIT on LATENCY=4 must drop the write.
        do_txn(2, 1'b1, 32'h40, 32'h0, 4'hF, 32'h0, 1'b0);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h40;
        req_wdata[2] = 32'h55555555; req_be[2] = 4'hF;
        tick();
        req_valid[2] = 1'b0;
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        chk("rstwait_req_ready", 32'(req_ready[2]), 32'd1);
        chk("rstwait_rsp_valid", 32'(rsp_valid[2]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rstwait_no_rsp", 32'(rsp_valid[2]), 32'd0);
        end
        do_txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0);

        // Back-to-back reads on LATENCY=1 with both handshakes held high.
        do_txn(0, 1'b1, 32'h30, 32'h600DCAFE, 4'hF, 32'h0, 1'b0);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h30;
        rsp_ready[0] = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (req_ready[0]) begin
                e.rdata = 32'h600DCAFE; e.err = 1'b0;
                sb.push_back(e);
                n_acc++;
            end
            tick();
            chk("b2b_rsp_valid", 32'(rsp_valid[0]), 32'((i % 2) == 0));
            chk("b2b_req_ready", 32'(req_ready[0]), 32'((i % 2) == 1));
            if (rsp_valid[0] && sb.size() > 0) begin
                e = sb.pop_front();
                chk("b2b_rsp_rdata", rsp_rdata[0], e.rdata);
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
        chk("b2b_accepts", 32'(n_acc), 32'd4);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two, 16..65536.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 req_be  input  4  byte enables for writes; bit i selects byte i (bits 8i+7:8i).
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  initiator accepts response.
REQ-013 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states: IDLE, WAIT, RESP; one outstanding transaction maximum.
REQ-016 req_ready = 1 only in IDLE; 0 in WAIT and RESP.
REQ-017 Acceptance = req_valid & req_ready at a rising edge; req_we, req_addr, req_wdata, req_be latched on that edge; inputs ignored afterwards.
REQ-018 On acceptance: LATENCY=1 -> RESP next; LATENCY>1 -> WAIT with down-counter loaded with LATENCY-2.
REQ-019 WAIT: counter decrements each cycle; at 0 transition to RESP; rsp_valid first high exactly LATENCY cycles after acceptance edge.
REQ-020 Memory access performed on the edge entering RESP: read captures mem[addr[log2(DEPTH_WORDS)+1:2]] into rsp_rdata; write updates only enabled bytes.
REQ-021 Error when latched addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS: no memory update, rsp_rdata = 0, rsp_err = 1.
REQ-022 Write with req_be = 4'b0000 is legal: no memory change, rsp_err = 0.
REQ-023 RESP: rsp_valid = 1, rsp_rdata/rsp_err held stable until rsp_valid & rsp_ready edge, then IDLE.
REQ-024 rsp_valid low in IDLE and WAIT; rsp_rdata and rsp_err 0 whenever rsp_valid = 0.
REQ-025 Earliest re-acceptance: cycle after response handshake (req_ready high in IDLE); minimum 2 + LATENCY-1 cycles per transaction, no overlap.
REQ-026 Read of a word written by the previous transaction returns the new value.

Reset
REQ-027 rst high at an edge: state IDLE, counter 0, req_ready 1 from next cycle, rsp_valid 0, rsp_rdata 0, rsp_err 0; rst dominates all other inputs.
REQ-028 Reset during WAIT abandons the transaction: pending write not performed, no response issued.
REQ-029 Memory contents not altered by reset; contents after power-up undefined until written.

Verification
REQ-030 LATENCY=2: write addr 0x10, wdata 0xDEADBEEF, be 4'hF accepted at edge N -> rsp_valid high after edge N+2, rsp_err 0; read 0x10 -> rsp_rdata 0xDEADBEEF.
REQ-031 Byte enables: word 0x20 = 0x11223344, write 0xAABBCCDD be 4'b0101 -> read 0x20 returns 0x11BB33DD.
REQ-032 Errors: read 0x13 -> rsp_err 1, rsp_rdata 0; write 0x1000 with DEPTH_WORDS=1024 -> rsp_err 1, subsequent read 0x0 unchanged.
REQ-033 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata stable all 5 cycles, req_ready 0; new req_valid ignored until handshake.
REQ-034 Reset mid-WAIT (LATENCY=4): write 0x55555555 to 0x40 (previously 0x0), assert rst 1 cycle after acceptance -> no response, req_ready 1 after reset, read 0x40 returns 0x0.
REQ-035 LATENCY=1 back-to-back with rsp_ready=1 and req_valid=1: acceptance every 2 cycles, rsp_valid on edge after each acceptance.
